// File: rtl/image_read_arbiter_if.sv
// Bundles the requester bus and the image-pipeline handshake of image_read_arbiter.
// The slave modport is the arbiter itself. The master modport is the surrounding
// system: the requesters plus the image/palette pipeline that returns img_color.
interface image_read_arbiter_if #(
  parameter int N       = 4,
  parameter int ADDR_W  = 20,
  parameter int COLOR_W = 12
);
  localparam int ID_W = $clog2(N);

  logic [N-1:0]        req;
  logic [N*ADDR_W-1:0] addr;
  logic [N-1:0]        gnt;
  logic [ADDR_W-1:0]   img_addr;
  logic [COLOR_W-1:0]  img_color;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [COLOR_W-1:0]  rsp_color;

  modport slave (
    input  req, addr, img_color,
    output gnt, img_addr, rsp_valid, rsp_id, rsp_color
  );

  modport master (
    output req, addr, img_color,
    input  gnt, img_addr, rsp_valid, rsp_id, rsp_color
  );
endinterface

// File: rtl/image_read_arbiter.sv
// Shares one image RAM -> palette RAM lookup pipeline among N requesters.
// At most one request is granted per cycle. Port 0 (scanout) can have strict
// priority. The remaining ports are served round-robin, and a starvation counter
// lets a waiting low-priority port override port 0 once it has waited too long.
// Each returned color is tagged with the ID of the requester that asked for it.
module image_read_arbiter #(
  parameter int N            = 4,
  parameter int ADDR_W       = 20,
  parameter int COLOR_W      = 12,
  parameter int LATENCY      = 2,
  parameter int HIPRI_EN     = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  image_read_arbiter_if.slave   bus
);

  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  // Returns the index of the lowest set bit; only meaningful when v != 0.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [N-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  // Starvation counter increment that stops at STARVE_LIMIT.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(STARVE_LIMIT)) ? c : c + 1'b1;
  endfunction

  logic [ID_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [ADDR_W-1:0] r_img_addr;
  logic              r_vld_p [0:LATENCY];
  logic [ID_W-1:0]   r_id_p  [0:LATENCY];

  logic              w_lo_pend;
  logic              w_starve;
  logic              w_hipri_win;
  logic [N-1:0]      w_cand;
  logic [N-1:0]      w_upper_mask;
  logic [N-1:0]      w_upper;
  logic [ID_W-1:0]   w_rr_idx;
  logic              w_gnt_any;
  logic              w_by_rr;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [N-1:0]      w_gnt;
  logic              w_lo_gnt;
  logic [ADDR_W-1:0] w_sel_addr;

  // Grant decision: port-0 priority unless starving, else masked round-robin after rr_ptr.
  always_comb begin
    w_lo_pend   = (HIPRI_EN != 0) && (|bus.req[N-1:1]);
    w_starve    = w_lo_pend && (r_starve_cnt == CNT_W'(STARVE_LIMIT));
    w_hipri_win = (HIPRI_EN != 0) && bus.req[0] && !w_starve;

    // A starving low-priority port must not lose the round-robin search to port 0.
    w_cand = bus.req;
    if (w_starve) w_cand[0] = 1'b0;

    // Ports strictly above rr_ptr are searched first; otherwise wrap to the bottom.
    for (int i = 0; i < N; i++) begin
      w_upper_mask[i] = (i > int'(r_rr_ptr));
    end
    w_upper  = w_cand & w_upper_mask;
    w_rr_idx = (|w_upper) ? lowest_idx(w_upper) : lowest_idx(w_cand);

    w_gnt_any = 1'b0;
    w_by_rr   = 1'b0;
    w_gnt_idx = '0;
    if (!reset) begin
      if (w_hipri_win) begin
        w_gnt_any = 1'b1;
      end else if (|w_cand) begin
        w_gnt_any = 1'b1;
        w_by_rr   = 1'b1;
        w_gnt_idx = w_rr_idx;
      end
    end

    w_gnt    = w_gnt_any ? (N'(1) << w_gnt_idx) : '0;
    w_lo_gnt = w_gnt_any && (w_gnt_idx != '0);
  end

  // Address of the granted port, sampled in the grant cycle.
  always_comb begin
    w_sel_addr = '0;
    for (int k = 0; k < N; k++) begin
      if (w_gnt_idx == ID_W'(k)) w_sel_addr = bus.addr[k*ADDR_W +: ADDR_W];
    end
  end

  // Arbitration state and the registered pipeline address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr     <= ID_W'(N - 1);
      r_starve_cnt <= '0;
      r_img_addr   <= '0;
    end else begin
      if (w_gnt_any) r_img_addr <= w_sel_addr;
      if (w_gnt_any && w_by_rr) r_rr_ptr <= w_gnt_idx;
      if (w_lo_gnt || !w_lo_pend) r_starve_cnt <= '0;
      else                        r_starve_cnt <= sat_inc(r_starve_cnt);
    end
  end

  // Tag pipeline: stage 0 aligns with img_addr, stage LATENCY aligns with img_color.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s <= LATENCY; s++) begin
        r_vld_p[s] <= 1'b0;
        r_id_p[s]  <= '0;
      end
    end else begin
      r_vld_p[0] <= w_gnt_any;
      r_id_p[0]  <= w_gnt_idx;
      for (int s = 1; s <= LATENCY; s++) begin
        r_vld_p[s] <= r_vld_p[s-1];
        r_id_p[s]  <= r_id_p[s-1];
      end
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.img_addr  = r_img_addr;
  assign bus.rsp_valid = r_vld_p[LATENCY];
  assign bus.rsp_id    = r_id_p[LATENCY];
  assign bus.rsp_color = bus.img_color;

endmodule

// File: tb/tb_image_read_arbiter.sv
// Bench for image_read_arbiter: two instances (port-0 priority and pure
// round-robin) see the same requester stimulus, and the bench plays the
// image/palette pipeline. A cycle-level model predicts grants, img_addr and
// tagged responses; directed literal expectations pin the model.
module tb_image_read_arbiter;

  localparam int NP    = 4;
  localparam int AW    = 20;
  localparam int CW    = 12;
  localparam int LAT   = 2;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] rq;
  logic [AW-1:0] ad [NP];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  image_read_arbiter_if #(.N(NP), .ADDR_W(AW), .COLOR_W(CW)) ifh ();
  image_read_arbiter_if #(.N(NP), .ADDR_W(AW), .COLOR_W(CW)) ifr ();

  image_read_arbiter #(.N(NP), .ADDR_W(AW), .COLOR_W(CW), .LATENCY(LAT),
                       .HIPRI_EN(1), .STARVE_LIMIT(LIMIT))
    dut_h (.clk(clk), .reset(reset), .bus(ifh));

  image_read_arbiter #(.N(NP), .ADDR_W(AW), .COLOR_W(CW), .LATENCY(LAT),
                       .HIPRI_EN(0), .STARVE_LIMIT(LIMIT))
    dut_r (.clk(clk), .reset(reset), .bus(ifr));

  assign ifh.req  = rq;
  assign ifr.req  = rq;
  assign ifh.addr = {ad[3], ad[2], ad[1], ad[0]};
  assign ifr.addr = {ad[3], ad[2], ad[1], ad[0]};

  // Palette contents seen by the bench pipeline.
  function automatic logic [CW-1:0] pal(input logic [AW-1:0] a);
    return a[11:0] ^ 12'hA5A;
  endfunction

  // Two-cycle image RAM -> palette RAM pipeline per instance.
  logic [AW-1:0] ah1 = '0, ah2 = '0, ar1 = '0, ar2 = '0;
  always @(posedge clk) begin
    ah1 <= ifh.img_addr;
    ah2 <= ah1;
    ar1 <= ifr.img_addr;
    ar2 <= ar1;
  end
  assign ifh.img_color = pal(ah2);
  assign ifr.img_color = pal(ar2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int            m_ptr [2] = '{NP - 1, NP - 1};
  int            m_cnt [2] = '{0, 0};
  logic [AW-1:0] m_img [2] = '{20'h0, 20'h0};
  bit            ev    [2][1024];
  int            eid   [2][1024];
  logic [CW-1:0] ecol  [2][1024];

  // Which port wins this cycle (-1: none), from the arbitration rules.
  function automatic int pick(input logic [NP-1:0] r, input int ptr, input int cnt,
                              input bit hip, output bit by_rr);
    bit lo, starve;
    int p;
    by_rr  = 1'b0;
    lo     = hip && (r[3:1] != 3'b000);
    starve = lo && (cnt == LIMIT);
    if (hip && r[0] && !starve) return 0;
    for (int i = 1; i <= NP; i++) begin
      p = (ptr + i) % NP;
      if (r[p] && !(starve && p == 0)) begin
        by_rr = 1'b1;
        return p;
      end
    end
    return -1;
  endfunction

  task automatic check_dut(input int d, input logic [NP-1:0] g, input logic [AW-1:0] ia,
                           input logic v, input logic [1:0] id, input logic [CW-1:0] col,
                           input logic [CW-1:0] icol);
    int    k;
    bit    rr;
    string tg;
    rr = 1'b0;
    tg = (d == 0) ? "hp" : "rr";
    if (reset) k = -1;
    else       k = pick(rq, m_ptr[d], m_cnt[d], d == 0, rr);
    chk({tg, "_gnt"}, g, (k < 0) ? 0 : (1 << k));
    chk({tg, "_img_addr"}, ia, m_img[d]);
    chk({tg, "_rsp_valid"}, v, ev[d][cyc]);
    if (ev[d][cyc]) begin
      chk({tg, "_rsp_id"}, id, eid[d][cyc]);
      chk({tg, "_rsp_color"}, col, ecol[d][cyc]);
    end
    chk({tg, "_color_pass"}, col, icol);
    if (reset) begin
      m_ptr[d] = NP - 1;
      m_cnt[d] = 0;
      m_img[d] = '0;
      for (int j = 1; j <= LAT + 1; j++) ev[d][cyc+j] = 1'b0;
    end else begin
      if (k >= 0) begin
        m_img[d]             = ad[k];
        ev[d][cyc+1+LAT]     = 1'b1;
        eid[d][cyc+1+LAT]    = k;
        ecol[d][cyc+1+LAT]   = pal(ad[k]);
        if (rr) m_ptr[d] = k;
      end
      if (d == 0) begin
        if (k >= 1 || rq[3:1] == 3'b000) m_cnt[d] = 0;
        else if (m_cnt[d] < LIMIT)       m_cnt[d] = m_cnt[d] + 1;
      end
    end
  endtask

  // Single compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    check_dut(0, ifh.gnt, ifh.img_addr, ifh.rsp_valid, ifh.rsp_id, ifh.rsp_color, ifh.img_color);
    check_dut(1, ifr.gnt, ifr.img_addr, ifr.rsp_valid, ifr.rsp_id, ifr.rsp_color, ifr.img_color);
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rq    = '0;
    repeat (2) nxt();
    reset = 1'b0;
  endtask

  int t3 [6] = '{1, 2, 3, 1, 2, 3};

  initial begin
    reset = 1'b1;
    rq    = '0;
    for (int i = 0; i < NP; i++) ad[i] = '0;
    repeat (3) nxt();
    @(negedge clk);
    chk("rst_gnt", ifh.gnt, 4'b0000);
    chk("rst_img_addr", ifh.img_addr, 20'h0);
    chk("rst_rsp_valid", ifh.rsp_valid, 1'b0);
    chk("rst_rsp_id", ifh.rsp_id, 2'd0);
    nxt();
    reset = 1'b0;
    nxt();

    // Single request from port 2.
    rq = 4'b0100; ad[2] = 20'h012C0;
    @(negedge clk); chk("t1_gnt", ifh.gnt, 4'b0100);
    nxt(); rq = '0;
    @(negedge clk); chk("t1_img_addr", ifh.img_addr, 20'h012C0);
    nxt();
    @(negedge clk); chk("t1_early_vld", ifh.rsp_valid, 1'b0);
    nxt();
    @(negedge clk);
    chk("t1_rsp_valid", ifh.rsp_valid, 1'b1);
    chk("t1_rsp_id", ifh.rsp_id, 2'd2);
    chk("t1_rsp_color", ifh.rsp_color, 12'h89A);
    nxt(); nxt();

    // Port 0 and port 1 together; port 0 drops after its grant.
    rq = 4'b0011; ad[0] = 20'h00100; ad[1] = 20'h00201;
    @(negedge clk); chk("t2_gnt0", ifh.gnt, 4'b0001);
    nxt(); rq = 4'b0010;
    @(negedge clk); chk("t2_gnt1", ifh.gnt, 4'b0010);
    nxt(); rq = '0;
    nxt();
    @(negedge clk); chk("t2_rsp0_id", ifh.rsp_id, 2'd0); chk("t2_rsp0_vld", ifh.rsp_valid, 1'b1);
    nxt();
    @(negedge clk); chk("t2_rsp1_id", ifh.rsp_id, 2'd1); chk("t2_rsp1_vld", ifh.rsp_valid, 1'b1);
    nxt();

    // Low-priority ports 1..3 held high: rotation and back-to-back responses.
    do_reset();
    rq = 4'b1110; ad[1] = 20'h00011; ad[2] = 20'h00022; ad[3] = 20'h00033;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 6)  chk("t3_rot", ifh.gnt, 4'b0001 << t3[i]);
      if (i >= 3) chk("t3_stream", ifh.rsp_valid, 1'b1);
      nxt();
    end
    rq = '0;
    repeat (4) nxt();

    // Port 0 against a starving port 3.
    do_reset();
    rq = 4'b1001; ad[0] = 20'h4B000; ad[3] = 20'h00333;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk("t4_starve", ifh.gnt, (i == 8 || i == 17) ? 4'b1000 : 4'b0001);
      nxt();
    end
    rq = '0;
    repeat (4) nxt();

    // Reset in the middle of two in-flight requests.
    rq = 4'b0010; ad[1] = 20'h11111;
    @(negedge clk); chk("t5_g0", ifh.gnt, 4'b0010);
    nxt(); rq = 4'b0100; ad[2] = 20'h22222;
    @(negedge clk); chk("t5_g1", ifh.gnt, 4'b0100);
    nxt(); reset = 1'b1;
    @(negedge clk); chk("t5_rst_gnt_h", ifh.gnt, 4'b0000); chk("t5_rst_gnt_r", ifr.gnt, 4'b0000);
    nxt(); reset = 1'b0; rq = 4'b1110;
    @(negedge clk);
    chk("t5_vld_c3", ifh.rsp_valid, 1'b0);
    chk("t5_ptr_h", ifh.gnt, 4'b0010);
    chk("t5_ptr_r", ifr.gnt, 4'b0010);
    nxt(); rq = '0;
    @(negedge clk); chk("t5_vld_c4", ifh.rsp_valid, 1'b0);
    repeat (4) nxt();

    // All four ports on the round-robin instance; port 2 drops before its grant.
    do_reset();
    rq = 4'b1111; ad[0] = 20'h00A00; ad[1] = 20'h00B01; ad[2] = 20'h00C02; ad[3] = 20'h00D03;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_rot", ifr.gnt, 4'b0001 << (i % 4));
      nxt();
    end
    rq = 4'b1011;
    @(negedge clk); chk("t6_g1", ifr.gnt, 4'b0010);
    nxt();
    @(negedge clk); chk("t6_skip2", ifr.gnt, 4'b1000);
    nxt(); rq = '0;
    nxt(); nxt();
    @(negedge clk);
    chk("t6_rsp_vld", ifr.rsp_valid, 1'b1);
    chk("t6_rsp_id", ifr.rsp_id, 2'd3);
    repeat (5) nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
